// File: rtl/mult_issue_sched.sv
// Issue scheduler and occupancy tracker for the shared pipelined multiplier.
// Grants the oldest ready multiply each cycle and follows its tag to the CDB writeback.
module mult_issue_sched #(
  parameter  int WIDTH       = 16,
  parameter  int MULT_STAGES = 4,
  parameter  int TAG_W       = 6,
  localparam int CNT_W       = $clog2(MULT_STAGES + 1)
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [WIDTH-1:0]       i_mult_req,
  input  logic [WIDTH*TAG_W-1:0] i_slot_tag,
  input  logic                   i_flush,
  input  logic                   i_cdb_stall,
  output logic [WIDTH-1:0]       o_gnt,
  output logic                   o_issue_valid,
  output logic [TAG_W-1:0]       o_issue_tag,
  output logic                   o_stage_en,
  output logic [MULT_STAGES-1:0] o_stage_valid,
  output logic                   o_wb_valid,
  output logic [TAG_W-1:0]       o_wb_tag,
  output logic [CNT_W-1:0]       o_inflight_cnt
);

  logic [MULT_STAGES-1:0] r_stage_valid;
  logic [TAG_W-1:0]       r_stage_tag [MULT_STAGES];
  logic [CNT_W-1:0]       r_inflight_cnt;

  logic                   w_stage_en;
  logic [WIDTH-1:0]       w_req_masked;
  logic [WIDTH-1:0]       w_gnt;
  logic                   w_issue_valid;
  logic [TAG_W-1:0]       w_issue_tag;
  logic [MULT_STAGES-1:0] w_valid_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  // A refused writeback freezes the whole pipe; no bubble collapse upstream of it.
  assign w_stage_en = ~(r_stage_valid[MULT_STAGES-1] & i_cdb_stall);

  // Slot 0 is oldest, so the lowest set bit wins; isolate it with x & -x.
  assign w_req_masked  = (w_stage_en & ~i_flush & i_reset_n) ? i_mult_req : '0;
  assign w_gnt         = w_req_masked & (~w_req_masked + WIDTH'(1));
  assign w_issue_valid = |w_gnt;

  always_comb begin
    w_issue_tag = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_gnt[i]) w_issue_tag = w_issue_tag | i_slot_tag[i*TAG_W +: TAG_W];
    end
  end

  always_comb begin
    w_valid_nxt = r_stage_valid;
    if (i_flush) begin
      w_valid_nxt = '0;
    end else if (w_stage_en) begin
      w_valid_nxt = {r_stage_valid[MULT_STAGES-2:0], w_issue_valid};
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int k = 0; k < MULT_STAGES; k++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_valid_nxt[k]);
    end
  end

  // Tags are left alone on flush; the cleared valid bits make them don't-care.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stage_valid  <= '0;
      r_inflight_cnt <= '0;
      for (int k = 0; k < MULT_STAGES; k++) r_stage_tag[k] <= '0;
    end else begin
      r_stage_valid  <= w_valid_nxt;
      r_inflight_cnt <= w_cnt_nxt;
      if (w_stage_en) begin
        r_stage_tag[0] <= w_issue_tag;
        for (int k = 1; k < MULT_STAGES; k++) r_stage_tag[k] <= r_stage_tag[k-1];
      end
    end
  end

  assign o_gnt          = w_gnt;
  assign o_issue_valid  = w_issue_valid;
  assign o_issue_tag    = w_issue_tag;
  assign o_stage_en     = w_stage_en;
  assign o_stage_valid  = r_stage_valid;
  assign o_wb_valid     = r_stage_valid[MULT_STAGES-1];
  assign o_wb_tag       = r_stage_tag[MULT_STAGES-1];
  assign o_inflight_cnt = r_inflight_cnt;

endmodule

// File: doc/mult_issue_sched.md
# mult_issue_sched

Issue scheduler and occupancy tracker for the shared pipelined multiplier in the issue stage. It picks the oldest ready multiply entry from the reservation station, one per cycle. It tracks each in-flight multiply's destination tag through the multiplier stages and freezes the pipe when the CDB refuses the multiplier's writeback. It also squashes all in-flight work on a branch flush.

## Interface
- WIDTH, 16: number of RS slots; slot 0 is oldest, slot WIDTH-1 youngest.
- MULT_STAGES, 4: multiplier pipeline depth, ≥2.
- TAG_W, 6: destination physical-register tag width.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mult_req  in  WIDTH  slot holds a ready FUNC_MULT instruction.
- slot_tag  in  WIDTH*TAG_W  destination tag per slot; slot i occupies bits [i*TAG_W +: TAG_W].
- flush  in  1  branch mispredict squash.
- cdb_stall  in  1  CDB arbiter refuses the multiplier result this cycle.
- gnt  out  WIDTH  one-hot grant to the issued slot (combinational).
- issue_valid  out  1  a multiply issues at this edge; equals |gnt.
- issue_tag  out  TAG_W  tag of the granted slot; 0 when no grant.
- stage_en  out  1  multiplier datapath advance enable.
- stage_valid  out  MULT_STAGES  occupancy of each multiplier stage.
- wb_valid  out  1  result in last stage is presented to the CDB.
- wb_tag  out  TAG_W  tag of the last-stage result.
- inflight_cnt  out  $clog2(MULT_STAGES+1)  count of set stage_valid bits.

## Operation
- Per-stage registers hold one valid bit and one tag per stage, forming a shift register indexed 0..MULT_STAGES-1.
- Pipe advance: stage_en = ~(stage_valid[MULT_STAGES-1] & cdb_stall).
- When stage_en=0:
  - the whole pipe holds, with no bubble collapse;
  - gnt=0.
- Grant rule: when stage_en=1 and flush=0, gnt = lowest-index set bit of mult_req. Otherwise gnt=0.
- On each edge with stage_en=1, stage[k+1] takes stage[k]. Stage 0 takes {issue_valid, issue_tag}.
- wb_valid = stage_valid[MULT_STAGES-1]. wb_tag is that stage's tag.
- A result leaves the pipe on any edge with wb_valid=1 and cdb_stall=0.
- Flush:
  - At the next edge, all stage_valid bits clear, regardless of cdb_stall. Flush overrides stall.
  - gnt=0 during the flush cycle.
  - Tags need not clear.
- inflight_cnt is registered. It updates to the popcount of next-state stage_valid.
- mult_req bits for non-multiply slots must already be 0. This is the upstream's responsibility and is not checked.

## Timing
- Reset (reset_n low, asynchronous): stage_valid=0, all stage tags=0, inflight_cnt=0. Therefore wb_valid=0, wb_tag=0, stage_en=1.
- gnt/issue_valid/issue_tag are forced 0 while reset_n is low.
- Grant is combinational from mult_req, flush, and state in the same cycle. The RS deallocates the slot at that edge.
- Latency: an issue at edge t is in stage 0 after t. wb_valid is first high in the cycle after edge t+MULT_STAGES-1 (MULT_STAGES cycles after the issue cycle), absent stalls.
- Each cycle of cdb_stall while wb_valid=1 adds one cycle to every in-flight op.
- cdb_stall while wb_valid=0 has no effect.
- Throughput: one issue per cycle. A full pipe with no stalls gives inflight_cnt=MULT_STAGES steady.
- Simultaneous events:
  - flush+cdb_stall: flush wins; the pipe empties.
  - flush+mult_req: no grant.
  - Last-stage writeback together with a new issue: both occur.
- Reset asserted mid-operation clears all state immediately. The first grant is possible in the first cycle after deassertion.

## Test plan
- WIDTH=16, MULT_STAGES=4, mult_req=16'h0001, slot_tag[0]=6'h2A, one cycle → gnt=16'h0001, issue_tag=6'h2A. wb_valid=1 with wb_tag=6'h2A exactly 4 cycles later, one cycle wide.
- mult_req=16'h8420 → gnt=16'h0020. Next cycle mult_req=16'h8400 → gnt=16'h0400.
- 4 back-to-back issues, then cdb_stall=1 for 3 cycles when first result is at wb → stage_en=0, gnt=0, wb_tag constant, inflight_cnt=4. Results then retire in issue order, one per cycle.
- 3 ops in flight, flush=1 for one cycle with mult_req=16'hFFFF → gnt=0, cdb_stall ignored. Next cycle stage_valid=0, inflight_cnt=0, and the grant resumes.
- Drop reset_n low asynchronously mid-cycle with 2 ops in flight → stage_valid, wb_valid, and inflight_cnt are 0 before the next edge. No stale writeback after release.
- cdb_stall=1 with an empty last stage and mult_req=16'h0002 → stage_en=1, gnt=16'h0002, normal issue.
